// File: rtl/plic_max_tree_pipe.sv
// plic_max_tree_pipe
//
// Pipelined find-max tree for the PLIC. One vector of NUM_OPERANDS
// (priority, identifier) pairs is accepted per input handshake and reduced
// through S = $clog2(NUM_OPERANDS) comparator levels. Every level is
// followed by a register. The winning priority and its identifier leave
// through a valid/ready output with full backpressure.
//
// Handshake: a transfer happens on a rising clk_i edge where valid and ready
// are both high. valid_o and the result stay stable while valid_o && !ready_i.
// ready_o is combinational from ready_i and the stage valid bits. There are no
// skid buffers, so up to S vectors are held in flight.
//
// Ports
//   clk_i                   clock, rising edge
//   rst_ni                  asynchronous active-low reset
//   valid_i / ready_o       input vector handshake
//   priorities_i            NUM_OPERANDS unsigned priorities
//   identifiers_i           NUM_OPERANDS identifiers
//   threshold_i             masking threshold (only used with the macro below)
//   valid_o / ready_i       result handshake
//   largest_priority_o      winning priority
//   identifier_of_largest_o identifier of the winner (lowest lane on ties)
//
// Configuration macro: PLIC_MAX_TREE_THRESHOLD_EN
//   When defined, operands with priority <= threshold_i become priority 0 /
//   id 0 before the tree, so an all-masked vector yields 0/0 ("no eligible
//   source"). When undefined, threshold_i is ignored.

module plic_max_tree_pipe #(
  parameter int NUM_OPERANDS      = 32,
  parameter int ID_BITWIDTH       = 5,
  parameter int PRIORITY_BITWIDTH = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [PRIORITY_BITWIDTH-1:0] priorities_i  [NUM_OPERANDS],
  input  logic [ID_BITWIDTH-1:0]       identifiers_i [NUM_OPERANDS],
  input  logic [PRIORITY_BITWIDTH-1:0] threshold_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [PRIORITY_BITWIDTH-1:0] largest_priority_o,
  output logic [ID_BITWIDTH-1:0]       identifier_of_largest_o
);

  localparam int S     = $clog2(NUM_OPERANDS);
  localparam int P     = 1 << S;   // padded lane count
  localparam int NODES = P - 1;    // total pair registers across all stages

  // Lanes after padding (and masking when enabled)
  logic [PRIORITY_BITWIDTH-1:0] lane_pri [P];
  logic [ID_BITWIDTH-1:0]       lane_id  [P];

  // All stage registers live in one flat array. Stage k occupies
  // entries [P - 2^(S-k) +: 2^(S-1-k)]; the last stage is the single entry
  // NODES-1, which drives the outputs directly.
  logic [PRIORITY_BITWIDTH-1:0] node_pri_q [NODES];
  logic [ID_BITWIDTH-1:0]       node_id_q  [NODES];
  logic [PRIORITY_BITWIDTH-1:0] node_pri_d [NODES];
  logic [ID_BITWIDTH-1:0]       node_id_d  [NODES];
  logic [NODES-1:0]             node_ld;

  logic [S-1:0] vld_q;
  logic [S-1:0] en;
  logic [S-1:0] up_vld;

`ifndef PLIC_MAX_TREE_THRESHOLD_EN
  logic unused_threshold;
  assign unused_threshold = ^threshold_i;
`endif

  // ---------------------------------------------------------------------
  // Input lanes: pad to a power of two, optionally mask by threshold
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < P; i++) begin : g_lane
    if (i < NUM_OPERANDS) begin : g_real
`ifdef PLIC_MAX_TREE_THRESHOLD_EN
      logic keep;
      assign keep        = priorities_i[i] > threshold_i;
      assign lane_pri[i] = keep ? priorities_i[i]  : '0;
      assign lane_id[i]  = keep ? identifiers_i[i] : '0;
`else
      assign lane_pri[i] = priorities_i[i];
      assign lane_id[i]  = identifiers_i[i];
`endif
    end else begin : g_pad
      assign lane_pri[i] = '0;
      assign lane_id[i]  = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Stage control: valid feeding each stage and the backward enable chain
  // ---------------------------------------------------------------------
  always_comb begin
    up_vld    = '0;
    up_vld[0] = valid_i;
    for (int k = 1; k < S; k++) begin
      up_vld[k] = vld_q[k-1];
    end
  end

  // A stage can advance when it is empty or the stage after it advances.
  // Evaluated from the output backwards so a full pipeline still accepts
  // in the same cycle as an output transfer.
  always_comb begin
    en        = '0;
    en[S-1]   = !vld_q[S-1] || ready_i;
    for (int k = S - 2; k >= 0; k--) begin
      en[k] = !vld_q[k] || en[k+1];
    end
  end

  assign ready_o = en[0];

  // ---------------------------------------------------------------------
  // Comparator levels
  // ---------------------------------------------------------------------
  for (genvar k = 0; k < S; k++) begin : g_stage
    localparam int WIDTH = 1 << (S - 1 - k);
    localparam int OFF   = P - (1 << (S - k));

    for (genvar i = 0; i < WIDTH; i++) begin : g_node
      logic [PRIORITY_BITWIDTH-1:0] l_pri;
      logic [PRIORITY_BITWIDTH-1:0] r_pri;
      logic [ID_BITWIDTH-1:0]       l_id;
      logic [ID_BITWIDTH-1:0]       r_id;
      logic                         left_wins;

      if (k == 0) begin : g_leaf
        assign l_pri = lane_pri[2*i];
        assign r_pri = lane_pri[2*i+1];
        assign l_id  = lane_id[2*i];
        assign r_id  = lane_id[2*i+1];
      end else begin : g_inner
        localparam int SRC = P - (1 << (S - k + 1));
        assign l_pri = node_pri_q[SRC+2*i];
        assign r_pri = node_pri_q[SRC+2*i+1];
        assign l_id  = node_id_q[SRC+2*i];
        assign r_id  = node_id_q[SRC+2*i+1];
      end

      // >= keeps the left (lower-index) operand on ties, so the overall
      // winner is the lowest lane holding the maximum.
      assign left_wins          = l_pri >= r_pri;
      assign node_pri_d[OFF+i]  = left_wins ? l_pri : r_pri;
      assign node_id_d[OFF+i]   = left_wins ? l_id  : r_id;
      // Data only moves with a valid item; bubbles leave the registers alone.
      assign node_ld[OFF+i]     = en[k] & up_vld[k];
    end
  end

  // ---------------------------------------------------------------------
  // Stage registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int j = 0; j < NODES; j++) begin
        node_pri_q[j] <= '0;
        node_id_q[j]  <= '0;
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        if (en[k]) begin
          vld_q[k] <= up_vld[k];
        end
      end
      for (int j = 0; j < NODES; j++) begin
        if (node_ld[j]) begin
          node_pri_q[j] <= node_pri_d[j];
          node_id_q[j]  <= node_id_d[j];
        end
      end
    end
  end

  assign valid_o                 = vld_q[S-1];
  assign largest_priority_o      = node_pri_q[NODES-1];
  assign identifier_of_largest_o = node_id_q[NODES-1];

endmodule

// File: tb/tb_plic_max_tree_pipe.sv
// Directed bench for plic_max_tree_pipe. Main instance: 4 operands,
// 4-bit ids, 3-bit priorities (S = 2). Second instance: 5 operands padded
// to 8 (S = 3). Inputs change 2 time units after a rising edge, outputs are
// sampled on the falling edge.

module tb_plic_max_tree_pipe;

  localparam int N   = 4;
  localparam int N5  = 5;
  localparam int IDW = 4;
  localparam int PW  = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- main DUT (N = 4) ----------------
  logic           valid_i, ready_o, valid_o, ready_i;
  logic [PW-1:0]  priorities_i  [N];
  logic [IDW-1:0] identifiers_i [N];
  logic [PW-1:0]  threshold_i;
  logic [PW-1:0]  largest_priority_o;
  logic [IDW-1:0] identifier_of_largest_o;

  plic_max_tree_pipe #(
    .NUM_OPERANDS(N), .ID_BITWIDTH(IDW), .PRIORITY_BITWIDTH(PW)
  ) dut (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .valid_i                (valid_i),
    .ready_o                (ready_o),
    .priorities_i           (priorities_i),
    .identifiers_i          (identifiers_i),
    .threshold_i            (threshold_i),
    .valid_o                (valid_o),
    .ready_i                (ready_i),
    .largest_priority_o     (largest_priority_o),
    .identifier_of_largest_o(identifier_of_largest_o)
  );

  // ---------------- second DUT (N = 5, padded to 8) ----------------
  logic           valid5_i, ready5_o, valid5_o, ready5_i;
  logic [PW-1:0]  pri5  [N5];
  logic [IDW-1:0] id5   [N5];
  logic [PW-1:0]  thr5;
  logic [PW-1:0]  lp5;
  logic [IDW-1:0] lid5;

  plic_max_tree_pipe #(
    .NUM_OPERANDS(N5), .ID_BITWIDTH(IDW), .PRIORITY_BITWIDTH(PW)
  ) dut5 (
    .clk_i                  (clk),
    .rst_ni                 (rst_n),
    .valid_i                (valid5_i),
    .ready_o                (ready5_o),
    .priorities_i           (pri5),
    .identifiers_i          (id5),
    .threshold_i            (thr5),
    .valid_o                (valid5_o),
    .ready_i                (ready5_i),
    .largest_priority_o     (lp5),
    .identifier_of_largest_o(lid5)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [PW+IDW-1:0] exp_q[$];
  logic [PW-1:0]  vp [N];
  logic [IDW-1:0] vd [N];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Every output transfer of the main DUT must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && valid_o === 1'b1 && ready_i === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_valid", 32'(valid_o), 32'd0);
      end else begin
        check_eq("result", 32'({largest_priority_o, identifier_of_largest_o}),
                 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Offers vp/vd, waits (bounded) for ready_o, records the expected result
  // and returns 2 time units after the transfer edge with valid_i low.
  task automatic send(input logic [PW-1:0] e_pri, input logic [IDW-1:0] e_id);
    int guard;
    valid_i       = 1'b1;
    priorities_i  = vp;
    identifiers_i = vd;
    guard = 0;
    @(negedge clk);
    while (ready_o !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) check_eq("accept_timeout", 32'(ready_o), 32'd1);
    else exp_q.push_back({e_pri, e_id});
    @(posedge clk);
    #2;
    valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || valid_o === 1'b1) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    valid_i     = 1'b0;
    ready_i     = 1'b1;
    threshold_i = '0;
    for (int i = 0; i < N; i++) begin
      priorities_i[i]  = '0;
      identifiers_i[i] = '0;
    end
    valid5_i = 1'b0;
    ready5_i = 1'b1;
    thr5     = '0;
    for (int i = 0; i < N5; i++) begin
      pri5[i] = '0;
      id5[i]  = '0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid_o", 32'(valid_o), 32'd0);
    check_eq("rst_ready_o", 32'(ready_o), 32'd1);
    check_eq("rst_pri", 32'(largest_priority_o), 32'd0);
    check_eq("rst_id", 32'(identifier_of_largest_o), 32'd0);
    check_eq("rst_valid5_o", 32'(valid5_o), 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single vector: result valid exactly 2 cycles after the handshake cycle
    vp = '{3'd2, 3'd7, 3'd5, 3'd1};
    vd = '{4'd3, 4'd9, 4'd4, 4'd6};
    send(3'd7, 4'd9);
    @(negedge clk);
    check_eq("lat_stage0", 32'(valid_o), 32'd0);
    @(negedge clk);
    check_eq("lat_valid", 32'(valid_o), 32'd1);
    @(negedge clk);
    check_eq("single_pulse", 32'(valid_o), 32'd0);
    wait_drain();

    // Tie-break: lowest index wins
    vp = '{3'd5, 3'd3, 3'd5, 3'd5};
    vd = '{4'd1, 4'd2, 4'd3, 4'd4};
    send(3'd5, 4'd1);
    wait_drain();

    // Threshold behaviour
    vp = '{3'd2, 3'd4, 3'd3, 3'd1};
    vd = '{4'd1, 4'd2, 4'd3, 4'd4};
`ifdef PLIC_MAX_TREE_THRESHOLD_EN
    threshold_i = 3'd4;
    send(3'd0, 4'd0);     // every operand masked
    threshold_i = 3'd2;
    send(3'd4, 4'd2);     // lane 1 survives
`else
    threshold_i = 3'd4;
    send(3'd4, 4'd2);     // threshold ignored
    vp = '{3'd0, 3'd0, 3'd0, 3'd0};
    vd = '{4'd9, 4'd8, 4'd7, 4'd6};
    send(3'd0, 4'd9);     // priority-0 operands compete, lane 0 wins
`endif
    threshold_i = '0;
    wait_drain();

    // Backpressure: pipeline of depth 2 fills, then ready_o drops
    ready_i = 1'b0;
    vp = '{3'd1, 3'd2, 3'd3, 3'd4};
    vd = '{4'd1, 4'd2, 4'd3, 4'd4};
    send(3'd4, 4'd4);
    vp = '{3'd6, 3'd6, 3'd0, 3'd0};
    vd = '{4'd8, 4'd9, 4'd10, 4'd11};
    send(3'd6, 4'd8);
    vp = '{3'd3, 3'd3, 3'd3, 3'd3};
    vd = '{4'd5, 4'd6, 4'd7, 4'd8};
    valid_i       = 1'b1;
    priorities_i  = vp;
    identifiers_i = vd;
    @(negedge clk);
    check_eq("bp_ready_low", 32'(ready_o), 32'd0);
    check_eq("bp_valid_o", 32'(valid_o), 32'd1);
    check_eq("bp_head", 32'({largest_priority_o, identifier_of_largest_o}), 32'({3'd4, 4'd4}));
    repeat (2) @(negedge clk);
    check_eq("bp_hold_ready", 32'(ready_o), 32'd0);
    check_eq("bp_hold_data", 32'({largest_priority_o, identifier_of_largest_o}), 32'({3'd4, 4'd4}));
    @(posedge clk);
    #2;
    ready_i = 1'b1;
    send(3'd3, 4'd5);     // accepted in the same cycle the head leaves
    vp = '{3'd1, 3'd0, 3'd7, 3'd7};
    vd = '{4'd12, 4'd13, 4'd14, 4'd15};
    send(3'd7, 4'd14);
    @(negedge clk);
    check_eq("no_bubble_a", 32'(valid_o), 32'd1);
    @(negedge clk);
    check_eq("no_bubble_b", 32'(valid_o), 32'd1);
    @(negedge clk);
    check_eq("bp_drained_valid", 32'(valid_o), 32'd0);
    check_eq("bp_drained_q", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #2;

    // N = 5 padded to 8: result after 3 cycles
    pri5 = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    id5  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7};
    valid5_i = 1'b1;
    @(negedge clk);
    check_eq("n5_ready", 32'(ready5_o), 32'd1);
    @(posedge clk);
    #2;
    valid5_i = 1'b0;
    @(negedge clk);
    check_eq("n5_lat0", 32'(valid5_o), 32'd0);
    @(negedge clk);
    check_eq("n5_lat1", 32'(valid5_o), 32'd0);
    @(negedge clk);
    check_eq("n5_valid", 32'(valid5_o), 32'd1);
    check_eq("n5_pri", 32'(lp5), 32'd1);
    check_eq("n5_id", 32'(lid5), 32'd7);
    @(negedge clk);
    check_eq("n5_pulse", 32'(valid5_o), 32'd0);
    @(posedge clk);
    #2;

    // Reset with two vectors in flight
    ready_i = 1'b0;
    vp = '{3'd1, 3'd6, 3'd2, 3'd3};
    vd = '{4'd2, 4'd11, 4'd3, 4'd4};
    send(3'd6, 4'd11);
    vp = '{3'd5, 3'd0, 3'd0, 3'd2};
    vd = '{4'd7, 4'd1, 4'd1, 4'd1};
    send(3'd5, 4'd7);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_eq("midrst_valid_o", 32'(valid_o), 32'd0);
    check_eq("midrst_ready_o", 32'(ready_o), 32'd1);
    check_eq("midrst_pri", 32'(largest_priority_o), 32'd0);
    check_eq("midrst_id", 32'(identifier_of_largest_o), 32'd0);
    @(posedge clk);
    #2;
    rst_n   = 1'b1;
    ready_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check_eq("post_rst_quiet", 32'(valid_o), 32'd0);
    end
    @(posedge clk);
    #2;
    vp = '{3'd2, 3'd2, 3'd6, 3'd1};
    vd = '{4'd1, 4'd2, 4'd13, 4'd4};
    send(3'd6, 4'd13);
    @(negedge clk);
    check_eq("post_rst_lat0", 32'(valid_o), 32'd0);
    @(negedge clk);
    check_eq("post_rst_valid", 32'(valid_o), 32'd1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute bound on run time
  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "simulation did not finish");
  end

endmodule
